// File: rtl/mips_result_scoreboard.sv
// ---------------------------------------------------------------------------
// mips_result_scoreboard
//
// Result checker that rides beside the MIPS datapath. Every issued
// instruction (pc_en) is decoded into a LATENCY-deep shadow pipeline. When it
// reaches the compare stage, the expected result is computed from the rs/rt
// operands observed in that cycle and compared with the observed rd value.
// The outcome is registered one cycle later as a pass/fail/skip pulse. The
// block also keeps saturating pass/fail counters, a sticky error flag and a
// capture of the most recent failing instruction.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   flush          drop every in-flight instruction, including this cycle's issue
//   pc_en          instruction valid at issue
//   inst           instruction word at issue
//   rs_value       observed rs operand at the compare stage
//   rt_value       observed rt operand at the compare stage
//   rd_value       observed result at the compare stage
//   err_clr        clear err_sticky and the last_err_* captures
//   op_done        1-cycle pulse, compared instruction matched
//   op_err         1-cycle pulse, compared instruction mismatched
//   op_skip        1-cycle pulse, retired instruction is not checkable
//   pass_cnt       saturating match count
//   fail_cnt       saturating mismatch count
//   err_sticky     set on any mismatch, cleared by err_clr
//   last_err_inst  instruction word of the most recent mismatch
//   last_err_exp   expected value of the most recent mismatch
// ---------------------------------------------------------------------------

package AluCtrlSig_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
endpackage

module mips_result_scoreboard
    import AluCtrlSig_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned LATENCY      = 3,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned CHECK_BRANCH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              pc_en,
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [DATA_W-1:0] rt_value,
    input  logic [DATA_W-1:0] rd_value,
    input  logic              err_clr,
    output logic              op_done,
    output logic              op_err,
    output logic              op_skip,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              err_sticky,
    output logic [31:0]       last_err_inst,
    output logic [DATA_W-1:0] last_err_exp
);

    localparam int unsigned CMP = LATENCY - 1;   // index of the compare stage

    // ------------------------------------------------------------------
    // Shadow pipeline: stage 0 captures the issue, stage CMP is compared.
    // ------------------------------------------------------------------
    logic        vld_q   [LATENCY];
    logic [5:0]  opc_q   [LATENCY];
    logic [5:0]  funct_q [LATENCY];
    logic [15:0] imm_q   [LATENCY];
    logic [31:0] inst_q  [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                vld_q[i]   <= 1'b0;
                opc_q[i]   <= '0;
                funct_q[i] <= '0;
                imm_q[i]   <= '0;
                inst_q[i]  <= '0;
            end
        end else begin
            // flush kills the same-cycle issue as well as everything in flight
            vld_q[0]   <= pc_en & ~flush;
            opc_q[0]   <= inst[31:26];
            funct_q[0] <= inst[5:0];
            imm_q[0]   <= inst[15:0];
            inst_q[0]  <= inst;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i]   <= vld_q[i-1] & ~flush;
                opc_q[i]   <= opc_q[i-1];
                funct_q[i] <= funct_q[i-1];
                imm_q[i]   <= imm_q[i-1];
                inst_q[i]  <= inst_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Expected-result computation at the compare stage
    // ------------------------------------------------------------------
    logic              cmp_vld;
    logic [5:0]        cmp_opc;
    logic [5:0]        cmp_funct;
    logic [DATA_W-1:0] cmp_imm_sx;
    logic [31:0]       cmp_inst;
    logic signed [15:0] cmp_imm_s;

    assign cmp_vld    = vld_q[CMP];
    assign cmp_opc    = opc_q[CMP];
    assign cmp_funct  = funct_q[CMP];
    assign cmp_inst   = inst_q[CMP];
    assign cmp_imm_s  = imm_q[CMP];
    // size cast of a signed operand sign-extends to DATA_W
    assign cmp_imm_sx = DATA_W'(cmp_imm_s);

    logic              checkable;
    logic [DATA_W-1:0] exp_val;

    always_comb begin
        checkable = 1'b0;
        exp_val   = '0;
        unique case (cmp_opc)
            OP_RTYPE: begin
                checkable = 1'b1;
                case (cmp_funct)
                    FN_ADD:  exp_val = rs_value + rt_value;
                    FN_SUB:  exp_val = rs_value - rt_value;
                    FN_AND:  exp_val = rs_value & rt_value;
                    FN_OR:   exp_val = rs_value | rt_value;
                    FN_XOR:  exp_val = rs_value ^ rt_value;
                    FN_NOR:  exp_val = ~(rs_value | rt_value);
                    FN_SLT:  exp_val[0] = ($signed(rs_value) < $signed(rt_value));
                    default: checkable = 1'b0;
                endcase
            end
            OP_ADDI: begin
                checkable = 1'b1;
                exp_val   = rs_value + cmp_imm_sx;
            end
            // a branch is only checkable when it is taken; the observed rd
            // then carries the sign-extended offset
            OP_BEQ: begin
                checkable = (CHECK_BRANCH != 0) && (rs_value == rt_value);
                exp_val   = cmp_imm_sx;
            end
            OP_BNE: begin
                checkable = (CHECK_BRANCH != 0) && (rs_value != rt_value);
                exp_val   = cmp_imm_sx;
            end
            OP_J, OP_LW, OP_SW: checkable = 1'b0;
            default:            checkable = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered result stage
    // ------------------------------------------------------------------
    logic              op_done_q, op_done_d;
    logic              op_err_q,  op_err_d;
    logic              op_skip_q, op_skip_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic              sticky_q, sticky_d;
    logic [31:0]       err_inst_q, err_inst_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;

    logic cmp_live;
    assign cmp_live = cmp_vld & ~flush;

    always_comb begin
        op_done_d  = cmp_live &  checkable & (exp_val == rd_value);
        op_err_d   = cmp_live &  checkable & (exp_val != rd_value);
        op_skip_d  = cmp_live & ~checkable;

        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        sticky_d   = sticky_q;
        err_inst_d = err_inst_q;
        err_exp_d  = err_exp_q;

        if (op_done_d && (pass_cnt_q != {CNT_W{1'b1}}))
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
        if (op_err_d && (fail_cnt_q != {CNT_W{1'b1}}))
            fail_cnt_d = fail_cnt_q + CNT_W'(1);

        // a mismatch in the same cycle as err_clr takes priority
        if (op_err_d) begin
            sticky_d   = 1'b1;
            err_inst_d = cmp_inst;
            err_exp_d  = exp_val;
        end else if (err_clr) begin
            sticky_d   = 1'b0;
            err_inst_d = '0;
            err_exp_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_done_q  <= 1'b0;
            op_err_q   <= 1'b0;
            op_skip_q  <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            sticky_q   <= 1'b0;
            err_inst_q <= '0;
            err_exp_q  <= '0;
        end else begin
            op_done_q  <= op_done_d;
            op_err_q   <= op_err_d;
            op_skip_q  <= op_skip_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            sticky_q   <= sticky_d;
            err_inst_q <= err_inst_d;
            err_exp_q  <= err_exp_d;
        end
    end

    assign op_done       = op_done_q;
    assign op_err        = op_err_q;
    assign op_skip       = op_skip_q;
    assign pass_cnt      = pass_cnt_q;
    assign fail_cnt      = fail_cnt_q;
    assign err_sticky    = sticky_q;
    assign last_err_inst = err_inst_q;
    assign last_err_exp  = err_exp_q;

endmodule

// File: tb/tb_mips_result_scoreboard.sv
// Bench for mips_result_scoreboard. Two instances share one stimulus stream:
// "a" uses the default parameters, "b" has CHECK_BRANCH=0 and CNT_W=2.
module tb_mips_result_scoreboard;

    localparam int LAT = 3;
    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_SLT  = 32'h0022182A;
    localparam logic [31:0] I_ADDI = 32'h2022FFFF;
    localparam logic [31:0] I_BEQ  = 32'h10220010;
    localparam logic [31:0] I_BNE  = 32'h14220010;
    localparam logic [31:0] I_ADD2 = 32'h00852020;

    logic        clk = 1'b0;
    logic        reset, flush, pc_en, err_clr;
    logic [31:0] inst, rs_value, rt_value, rd_value;

    logic        a_op_done, a_op_err, a_op_skip, a_err_sticky;
    logic [15:0] a_pass_cnt, a_fail_cnt;
    logic [31:0] a_last_err_inst, a_last_err_exp;
    logic        b_op_done, b_op_err, b_op_skip, b_err_sticky;
    logic [1:0]  b_pass_cnt, b_fail_cnt;
    logic [31:0] b_last_err_inst, b_last_err_exp;

    mips_result_scoreboard #(.DATA_W(32), .LATENCY(LAT), .CNT_W(16), .CHECK_BRANCH(1)) u_a (
        .clk(clk), .reset(reset), .flush(flush), .pc_en(pc_en), .inst(inst),
        .rs_value(rs_value), .rt_value(rt_value), .rd_value(rd_value), .err_clr(err_clr),
        .op_done(a_op_done), .op_err(a_op_err), .op_skip(a_op_skip),
        .pass_cnt(a_pass_cnt), .fail_cnt(a_fail_cnt), .err_sticky(a_err_sticky),
        .last_err_inst(a_last_err_inst), .last_err_exp(a_last_err_exp));

    mips_result_scoreboard #(.DATA_W(32), .LATENCY(LAT), .CNT_W(2), .CHECK_BRANCH(0)) u_b (
        .clk(clk), .reset(reset), .flush(flush), .pc_en(pc_en), .inst(inst),
        .rs_value(rs_value), .rt_value(rt_value), .rd_value(rd_value), .err_clr(err_clr),
        .op_done(b_op_done), .op_err(b_op_err), .op_skip(b_op_skip),
        .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt), .err_sticky(b_err_sticky),
        .last_err_inst(b_last_err_inst), .last_err_exp(b_last_err_exp));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] ins;
        int          cyc;
    } iss_t;

    iss_t        q[$];
    int          cyc = 0;
    int          m_pass[2], m_fail[2], m_max[2];
    bit          m_sticky[2], m_done[2], m_err[2], m_skip[2];
    logic [31:0] m_inst[2], m_exp[2];

    function automatic void ref_eval(input logic [31:0] ins, input logic [31:0] rs,
                                     input logic [31:0] rt, input bit chk,
                                     output bit skip, output logic [31:0] ex);
        logic [31:0] imm;
        imm  = {{16{ins[15]}}, ins[15:0]};
        skip = 1'b0;
        ex   = 32'd0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20:   ex = rs + rt;
                6'h22:   ex = rs - rt;
                6'h24:   ex = rs & rt;
                6'h25:   ex = rs | rt;
                6'h26:   ex = rs ^ rt;
                6'h27:   ex = ~(rs | rt);
                6'h2A:   ex = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                default: skip = 1'b1;
            endcase
            6'h08:   ex = rs + imm;
            6'h04:   if (chk && rs == rt) ex = imm; else skip = 1'b1;
            6'h05:   if (chk && rs != rt) ex = imm; else skip = 1'b1;
            default: skip = 1'b1;
        endcase
    endfunction

    task automatic model_clear();
        q.delete();
        m_max[0] = 65535;
        m_max[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_pass[k] = 0; m_fail[k] = 0; m_sticky[k] = 0;
            m_done[k] = 0; m_err[k] = 0; m_skip[k] = 0;
            m_inst[k] = 0; m_exp[k] = 0;
        end
    endtask

    // advance the model over one clock edge using the current inputs,
    // then wait for the edge and step 1 time unit past it
    task automatic tick();
        bit          due, sk;
        logic [31:0] ci, ex;
        due = 0;
        ci  = 0;
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0; m_err[k] = 0; m_skip[k] = 0;
        end
        if (q.size() > 0 && q[0].cyc == cyc - LAT) begin
            due = 1;
            ci  = q[0].ins;
            void'(q.pop_front());
        end
        if (flush) begin
            q.delete();
        end else begin
            if (due) begin
                for (int k = 0; k < 2; k++) begin
                    ref_eval(ci, rs_value, rt_value, (k == 0), sk, ex);
                    if (sk) m_skip[k] = 1;
                    else if (ex == rd_value) begin
                        m_done[k] = 1;
                        if (m_pass[k] < m_max[k]) m_pass[k]++;
                    end else begin
                        m_err[k] = 1;
                        if (m_fail[k] < m_max[k]) m_fail[k]++;
                        m_sticky[k] = 1; m_inst[k] = ci; m_exp[k] = ex;
                    end
                end
            end
            if (pc_en) q.push_back('{ins: inst, cyc: cyc});
        end
        for (int k = 0; k < 2; k++)
            if (err_clr && !m_err[k]) begin
                m_sticky[k] = 0; m_inst[k] = 0; m_exp[k] = 0;
            end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; flush = 0; pc_en = 0; err_clr = 0;
        inst = 0; rs_value = 0; rt_value = 0; rd_value = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    // issue one instruction and drive its operands in its compare cycle
    task automatic run_one(input logic [31:0] ins, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] rd);
        pc_en = 1; inst = ins;
        tick();
        pc_en = 0; inst = 0;
        repeat (LAT - 1) tick();
        rs_value = rs; rt_value = rt; rd_value = rd;
        tick();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 12))
            0:  begin r[31:26] = 6'h00; r[5:0] = 6'h20; end
            1:  begin r[31:26] = 6'h00; r[5:0] = 6'h22; end
            2:  begin r[31:26] = 6'h00; r[5:0] = 6'h24; end
            3:  begin r[31:26] = 6'h00; r[5:0] = 6'h25; end
            4:  begin r[31:26] = 6'h00; r[5:0] = 6'h26; end
            5:  begin r[31:26] = 6'h00; r[5:0] = 6'h27; end
            6:  begin r[31:26] = 6'h00; r[5:0] = 6'h2A; end
            7:  begin r[31:26] = 6'h00; r[5:0] = 6'h00; end
            8:  r[31:26] = 6'h08;
            9:  r[31:26] = 6'h04;
            10: r[31:26] = 6'h05;
            11: case ($urandom_range(0, 2))
                    0:       r[31:26] = 6'h02;
                    1:       r[31:26] = 6'h23;
                    default: r[31:26] = 6'h2B;
                endcase
            default: r[31:26] = 6'h3F;
        endcase
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if ({a_op_done, a_op_err, a_op_skip, a_err_sticky} !== 4'b0) begin n_fail++; $display("FAIL reset_a_flags got=%b exp=0000", {a_op_done, a_op_err, a_op_skip, a_err_sticky}); end
        n_checks++; if ({a_pass_cnt, a_fail_cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_a_cnt got=%h exp=0", {a_pass_cnt, a_fail_cnt}); end
        n_checks++; if ({a_last_err_inst, a_last_err_exp} !== 64'h0) begin n_fail++; $display("FAIL reset_a_capt got=%h exp=0", {a_last_err_inst, a_last_err_exp}); end
        n_checks++; if ({b_op_done, b_op_err, b_op_skip, b_err_sticky, b_pass_cnt, b_fail_cnt} !== 8'h0) begin n_fail++; $display("FAIL reset_b got=%h exp=0", {b_op_done, b_op_err, b_op_skip, b_err_sticky, b_pass_cnt, b_fail_cnt}); end
    endtask

    task automatic test_add();
        int late;
        pc_en = 1; inst = I_ADD;
        tick();
        pc_en = 0; inst = 0;
        late = 0;
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            if (a_op_done | a_op_err | a_op_skip) late++;
        end
        rs_value = 5; rt_value = 7; rd_value = 12;
        tick();
        n_checks++; if (late != 0) begin n_fail++; $display("FAIL add_early_pulse got=%0d exp=0", late); end
        n_checks++; if ({a_op_done, a_op_err, a_op_skip} !== 3'b100) begin n_fail++; $display("FAIL add_pulse got=%b exp=100", {a_op_done, a_op_err, a_op_skip}); end
        n_checks++; if (a_pass_cnt !== 16'd1) begin n_fail++; $display("FAIL add_pass_cnt got=%0d exp=1", a_pass_cnt); end
        tick();
        n_checks++; if ({a_op_done, a_op_err, a_op_skip} !== 3'b000) begin n_fail++; $display("FAIL add_one_cycle got=%b exp=000", {a_op_done, a_op_err, a_op_skip}); end
    endtask

    task automatic test_sub();
        run_one(I_SUB, 32'h10, 32'h20, 32'hFFFF_FFF0);
        n_checks++; if (a_op_done !== 1'b1 || a_pass_cnt !== 16'd2) begin n_fail++; $display("FAIL sub_match got=%b/%0d exp=1/2", a_op_done, a_pass_cnt); end
        run_one(I_SUB, 32'h10, 32'h20, 32'h0);
        n_checks++; if ({a_op_done, a_op_err, a_op_skip} !== 3'b010) begin n_fail++; $display("FAIL sub_err_pulse got=%b exp=010", {a_op_done, a_op_err, a_op_skip}); end
        n_checks++; if (a_fail_cnt !== 16'd1 || a_err_sticky !== 1'b1) begin n_fail++; $display("FAIL sub_err_state got=%0d/%b exp=1/1", a_fail_cnt, a_err_sticky); end
        n_checks++; if (a_last_err_exp !== 32'hFFFF_FFF0 || a_last_err_inst !== I_SUB) begin n_fail++; $display("FAIL sub_capture got=%h/%h exp=fffffff0/%h", a_last_err_exp, a_last_err_inst, I_SUB); end
        n_checks++; if (b_fail_cnt !== 2'd1 || b_err_sticky !== 1'b1) begin n_fail++; $display("FAIL sub_b_err got=%0d/%b exp=1/1", b_fail_cnt, b_err_sticky); end
    endtask

    task automatic test_slt_addi();
        run_one(I_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        n_checks++; if ({a_op_done, a_op_err, a_op_skip} !== 3'b100) begin n_fail++; $display("FAIL slt_signed got=%b exp=100", {a_op_done, a_op_err, a_op_skip}); end
        run_one(I_ADDI, 32'd5, 32'd0, 32'd4);
        n_checks++; if ({a_op_done, a_op_err, a_op_skip} !== 3'b100) begin n_fail++; $display("FAIL addi_sext got=%b exp=100", {a_op_done, a_op_err, a_op_skip}); end
        n_checks++; if (a_pass_cnt !== 16'd4) begin n_fail++; $display("FAIL slt_addi_cnt got=%0d exp=4", a_pass_cnt); end
    endtask

    task automatic test_branch();
        run_one(I_BEQ, 32'd9, 32'd9, 32'h10);
        n_checks++; if ({a_op_done, a_op_err, a_op_skip} !== 3'b100) begin n_fail++; $display("FAIL beq_taken_a got=%b exp=100", {a_op_done, a_op_err, a_op_skip}); end
        n_checks++; if ({b_op_done, b_op_err, b_op_skip} !== 3'b001) begin n_fail++; $display("FAIL beq_nochk_b got=%b exp=001", {b_op_done, b_op_err, b_op_skip}); end
        run_one(I_BNE, 32'd9, 32'd9, 32'h10);
        n_checks++; if ({a_op_done, a_op_err, a_op_skip, b_op_skip} !== 4'b0011) begin n_fail++; $display("FAIL bne_not_taken got=%b exp=0011", {a_op_done, a_op_err, a_op_skip, b_op_skip}); end
        n_checks++; if (a_pass_cnt !== 16'd5 || a_fail_cnt !== 16'd1) begin n_fail++; $display("FAIL bne_skip_cnt got=%0d/%0d exp=5/1", a_pass_cnt, a_fail_cnt); end
        run_one(I_BNE, 32'd3, 32'd4, 32'h10);
        n_checks++; if ({a_op_done, b_op_skip} !== 2'b11) begin n_fail++; $display("FAIL bne_taken got=%b exp=11", {a_op_done, b_op_skip}); end
    endtask

    task automatic test_flush();
        int seen;
        rs_value = 1; rt_value = 2; rd_value = 32'd99;
        pc_en = 1; inst = I_ADD;
        tick(); tick(); tick();
        flush = 1;
        tick();
        flush = 0; pc_en = 0; inst = 0;
        seen = 0;
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            seen += int'(a_op_done) + int'(a_op_err) + int'(a_op_skip) + int'(b_op_done) + int'(b_op_err) + int'(b_op_skip);
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_pulses got=%0d exp=0", seen); end
        n_checks++; if (a_fail_cnt !== 16'(m_fail[0]) || a_pass_cnt !== 16'(m_pass[0])) begin n_fail++; $display("FAIL flush_cnt got=%0d/%0d exp=%0d/%0d", a_pass_cnt, a_fail_cnt, m_pass[0], m_fail[0]); end
        run_one(I_ADD, 32'd1, 32'd2, 32'd3);
        n_checks++; if ({a_op_done, a_op_err, a_op_skip} !== 3'b100) begin n_fail++; $display("FAIL flush_after got=%b exp=100", {a_op_done, a_op_err, a_op_skip}); end
    endtask

    task automatic test_err_clr();
        pc_en = 1; inst = I_ADD2;
        tick();
        pc_en = 0; inst = 0;
        repeat (LAT - 1) tick();
        rs_value = 1; rt_value = 2; rd_value = 0; err_clr = 1;
        tick();
        err_clr = 0;
        n_checks++; if (a_op_err !== 1'b1 || a_err_sticky !== 1'b1) begin n_fail++; $display("FAIL errclr_race got=%b/%b exp=1/1", a_op_err, a_err_sticky); end
        n_checks++; if (a_last_err_inst !== I_ADD2 || a_last_err_exp !== 32'd3) begin n_fail++; $display("FAIL errclr_capture got=%h/%h exp=%h/3", a_last_err_inst, a_last_err_exp, I_ADD2); end
        err_clr = 1;
        tick();
        err_clr = 0;
        n_checks++; if ({a_err_sticky, a_last_err_inst, a_last_err_exp} !== 65'h0) begin n_fail++; $display("FAIL errclr_clear got=%b/%h/%h exp=0", a_err_sticky, a_last_err_inst, a_last_err_exp); end
        n_checks++; if (a_fail_cnt !== 16'(m_fail[0]) || m_fail[0] != 2) begin n_fail++; $display("FAIL errclr_cnt got=%0d exp=2", a_fail_cnt); end
    endtask

    task automatic test_saturation();
        int dones;
        do_reset();
        dones = 0;
        rs_value = 2; rt_value = 3; rd_value = 5;
        for (int i = 0; i < 5 + LAT; i++) begin
            pc_en = (i < 5); inst = I_ADD;
            tick();
            if (a_op_done === 1'b1) dones++;
        end
        pc_en = 0;
        n_checks++; if (dones != 5) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=5", dones); end
        n_checks++; if (b_pass_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_pass got=%0d exp=3", b_pass_cnt); end
        n_checks++; if (a_pass_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_a_pass got=%0d exp=5", a_pass_cnt); end
    endtask

    task automatic test_async_reset();
        int seen;
        run_one(I_ADD, 32'd1, 32'd1, 32'd5);
        pc_en = 1; inst = I_ADD;
        tick(); tick();
        pc_en = 0; inst = 0;
        #3;
        reset = 1;
        #1;
        n_checks++; if ({a_op_done, a_op_err, a_op_skip, a_err_sticky, a_pass_cnt, a_fail_cnt} !== 36'h0) begin n_fail++; $display("FAIL areset_a got=%h exp=0", {a_op_done, a_op_err, a_op_skip, a_err_sticky, a_pass_cnt, a_fail_cnt}); end
        n_checks++; if ({a_last_err_inst, a_last_err_exp, b_err_sticky, b_pass_cnt, b_fail_cnt} !== 69'h0) begin n_fail++; $display("FAIL areset_capt got=%h exp=0", {a_last_err_inst, a_last_err_exp, b_err_sticky, b_pass_cnt, b_fail_cnt}); end
        model_clear();
        @(posedge clk);
        #1;
        reset = 0;
        rs_value = 1; rt_value = 1; rd_value = 2;
        seen = 0;
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            seen += int'(a_op_done) + int'(a_op_err) + int'(a_op_skip);
        end
        pc_en = 1; inst = I_ADD;
        tick();
        pc_en = 0; inst = 0;
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            seen += int'(a_op_done) + int'(a_op_err) + int'(a_op_skip);
        end
        rs_value = 4; rt_value = 4; rd_value = 8;
        tick();
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL areset_stale got=%0d exp=0", seen); end
        n_checks++; if (a_op_done !== 1'b1 || a_pass_cnt !== 16'd1) begin n_fail++; $display("FAIL areset_first got=%b/%0d exp=1/1", a_op_done, a_pass_cnt); end
    endtask

    task automatic test_random();
        bit          sk;
        logic [31:0] ex;
        for (int n = 0; n < 400; n++) begin
            pc_en   = ($urandom_range(0, 9) < 7);
            inst    = rand_inst();
            flush   = ($urandom_range(0, 29) == 0);
            err_clr = ($urandom_range(0, 19) == 0);
            rs_value = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            rt_value = ($urandom_range(0, 1) == 0) ? rs_value : $urandom;
            rd_value = $urandom;
            if (q.size() > 0 && q[0].cyc == cyc - LAT) begin
                ref_eval(q[0].ins, rs_value, rt_value, 1'b1, sk, ex);
                if ($urandom_range(0, 3) != 0) rd_value = ex;
            end
            tick();
            n_checks++; if ({a_op_done, a_op_err, a_op_skip} !== {m_done[0], m_err[0], m_skip[0]}) begin n_fail++; $display("FAIL rnd_a_pulse n=%0d got=%b exp=%b", n, {a_op_done, a_op_err, a_op_skip}, {m_done[0], m_err[0], m_skip[0]}); end
            n_checks++; if ({b_op_done, b_op_err, b_op_skip} !== {m_done[1], m_err[1], m_skip[1]}) begin n_fail++; $display("FAIL rnd_b_pulse n=%0d got=%b exp=%b", n, {b_op_done, b_op_err, b_op_skip}, {m_done[1], m_err[1], m_skip[1]}); end
            n_checks++; if (a_pass_cnt !== 16'(m_pass[0]) || a_fail_cnt !== 16'(m_fail[0])) begin n_fail++; $display("FAIL rnd_a_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, a_pass_cnt, a_fail_cnt, m_pass[0], m_fail[0]); end
            n_checks++; if (b_pass_cnt !== 2'(m_pass[1]) || b_fail_cnt !== 2'(m_fail[1])) begin n_fail++; $display("FAIL rnd_b_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, b_pass_cnt, b_fail_cnt, m_pass[1], m_fail[1]); end
            n_checks++; if ({a_err_sticky, a_last_err_inst, a_last_err_exp} !== {m_sticky[0], m_inst[0], m_exp[0]}) begin n_fail++; $display("FAIL rnd_a_err n=%0d got=%b/%h/%h exp=%b/%h/%h", n, a_err_sticky, a_last_err_inst, a_last_err_exp, m_sticky[0], m_inst[0], m_exp[0]); end
            n_checks++; if ({b_err_sticky, b_last_err_inst, b_last_err_exp} !== {m_sticky[1], m_inst[1], m_exp[1]}) begin n_fail++; $display("FAIL rnd_b_err n=%0d got=%b/%h/%h exp=%b/%h/%h", n, b_err_sticky, b_last_err_inst, b_last_err_exp, m_sticky[1], m_inst[1], m_exp[1]); end
        end
        pc_en = 0; flush = 0; err_clr = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt_addi();
        test_branch();
        test_flush();
        test_err_clr();
        test_saturation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_result_scoreboard.md
Name: mips_result_scoreboard

Overview:
Parametrised result checker for the MIPS datapath. It decodes each issued instruction and carries it through a LATENCY-deep shadow pipeline. When the instruction reaches writeback it computes the expected result from the observed rs/rt operands and compares it with the observed rd value. It reports per-instruction pass, fail or skip pulses, saturating pass/fail counters, a sticky error flag, and a capture of the last failing instruction. It sits beside the DUT in the testbench and in the emulation top, on the same clock.

Parameters:
DATA_W, 32, width of rs/rt/rd values and expected result
LATENCY, 3, cycles from issue (pc_en) to writeback compare; legal range 1..8
CNT_W, 16, width of pass/fail counters
CHECK_BRANCH, 1, 1 = check BEQ/BNE offsets; 0 = treat branches as skip

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
flush  in  1  invalidate all in-flight instructions (taken branch/jump)
pc_en  in  1  inst valid this cycle (issue)
inst  in  32  instruction word at issue
rs_value  in  DATA_W  observed rs operand at writeback stage
rt_value  in  DATA_W  observed rt operand at writeback stage
rd_value  in  DATA_W  observed result at writeback stage
err_clr  in  1  clear err_sticky and last_err_* captures
op_done  out  1  1-cycle pulse: compared instruction matched
op_err  out  1  1-cycle pulse: compared instruction mismatched
op_skip  out  1  1-cycle pulse: retired instruction not checkable
pass_cnt  out  CNT_W  saturating match count
fail_cnt  out  CNT_W  saturating mismatch count
err_sticky  out  1  set on any mismatch
last_err_inst  out  32  instruction word of most recent mismatch
last_err_exp  out  DATA_W  expected value of most recent mismatch

Behaviour:
- Clock port is clk; reset port is reset, asynchronous and active-high. While reset is high, all outputs, counters and pipeline valid bits are 0, and captures are 0.
- Decode at issue, using AluCtrlSig_pkg constants: R-type 0x00 (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A), ADDI 0x08, BEQ 0x04, BNE 0x05, J 0x02, LW 0x23, SW 0x2B.
- Each shadow stage holds: valid, opcode, funct, imm16, the full inst word.
- An issue at cycle t with pc_en=1 reaches the compare stage at t+LATENCY. The compare uses the rs/rt/rd values present in that cycle. Result outputs are registered and visible at t+LATENCY+1.
- Expected values:
  - ADD/SUB: wrap modulo 2^DATA_W.
  - AND/OR/XOR/NOR: bitwise.
  - SLT: signed compare, result 1 or 0 zero-extended.
  - ADDI: rs + sign-extended imm16.
  - BEQ (rs==rt) / BNE (rs!=rt) taken: sign-extended imm16.
- Skip cases, which pulse op_skip and leave the counters unchanged:
  - branch not taken
  - CHECK_BRANCH=0 with any branch
  - J, LW, SW
  - unknown opcode or funct
- Exactly one of op_done/op_err/op_skip pulses per valid compare. All three stay 0 when the compare stage is invalid.
- On mismatch:
  - op_err=1
  - fail_cnt+1, saturating at all-ones
  - err_sticky=1
  - last_err_inst and last_err_exp captured
- On match: op_done=1 and pass_cnt+1, saturating.
- flush clears every in-flight valid bit, including the compare stage and the pc_en issue in the same cycle. No result pulse follows from any of them.
- If err_clr and a new mismatch occur in the same cycle, the mismatch wins: sticky stays set and the capture is updated. err_clr does not affect the counters.
- Back-to-back issue every cycle is supported; throughput is 1 per cycle.
- Reset asserted mid-operation drops all in-flight instructions. The first compare after release is LATENCY cycles after the first new issue.
- Implementation: a shift-register pipeline of LATENCY stages plus one registered result stage. No other state machine.

Test Plan:
- ADD, LATENCY=3: issue 0x00221820 at t; at t+3 drive rs=5, rt=7, rd=12 -> op_done=1 at t+4, pass_cnt=1.
- SUB mismatch: rs=0x10, rt=0x20, rd=0xFFFFFFF0 passes. Then rd=0 -> op_err=1, fail_cnt=1, err_sticky=1, last_err_exp=0xFFFFFFF0.
- SLT signed and ADDI sign-extension:
  - rs=0xFFFFFFFF, rt=1, rd=1 -> op_done.
  - ADDI imm=0xFFFF, rs=5, rd=4 -> op_done.
- Branches:
  - BEQ rs=rt=9, imm=0x0010, rd=0x10 -> op_done.
  - BNE with rs=rt -> op_skip.
  - CHECK_BRANCH=0 -> op_skip for both.
- Flush: issue 3 back-to-back ADDs, assert flush on the cycle of the 3rd issue -> no pulses for any of the three. A 4th issue after the flush compares normally.
- Saturation, CNT_W=2: 5 matches -> pass_cnt=3. err_clr in the same cycle as a mismatch -> err_sticky stays 1. Async reset mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
